// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte/word helpers for the round sequencer.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } fsm_state_t;

    // Index 0 sits in the most significant byte of the packed table.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rotword(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // One step of the AES-128 key schedule: word 0 picks up the rcon term, the rest chain.
    function automatic block_t next_round_key(input block_t rk, input logic [7:0] rcon);
        logic [31:0] t, w0, w1, w2, w3;
        t  = subword(rotword(rk[31:0])) ^ {rcon, 24'h000000};
        w0 = rk[127:96] ^ t;
        w1 = rk[95:64]  ^ w0;
        w2 = rk[63:32]  ^ w1;
        w3 = rk[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block request/response handshake between a requester and the AES round sequencer.
interface aes_round_sequencer_if;

    logic            in_valid;
    logic            in_ready;
    aes_pkg::block_t in_data;
    aes_pkg::block_t in_key;
    logic            out_valid;
    logic            out_ready;
    aes_pkg::block_t out_data;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on the final round), AddRoundKey.
// Latency: zero cycles; no flow control of its own.
module aes_round
    import aes_pkg::*;
(
    input  block_t state,
    input  block_t round_key,
    input  logic   final_round,
    output block_t next_state
);

    function automatic logic [31:0] mix_column(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    block_t subbed;
    block_t shifted;
    block_t mixed;

    always_comb begin
        subbed  = '0;
        shifted = '0;
        mixed   = '0;
        for (int i = 0; i < 16; i++) begin
            subbed[127-8*i -: 8] = sbox(state[127-8*i -: 8]);
        end
        // Byte 4*c+r is row r, column c; row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(4*c+r) -: 8] = subbed[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
        end
    end

    assign next_state = (final_round ? shifted : mixed) ^ round_key;

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryptor, one round per clock with the key schedule computed on the fly.
// Latency: NR edges accept->out_valid; out_data holds until out_ready, in_ready low while a block is in flight.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    aes_round_sequencer_if.slave        bus,
    output logic                        busy,
    output logic [3:0]                  round_idx
);

    fsm_state_t fsm_q;
    block_t     state_q;
    block_t     rk_q;
    block_t     rk_next;
    block_t     round_out;
    logic [7:0] rcon_q;
    logic       out_valid_q;
    logic       idle_rdy_q;
    logic       final_round;

    assign rk_next     = next_round_key(rk_q, rcon_q);
    assign final_round = (round_idx == 4'(NR));

    aes_round u_round (
        .state      (state_q),
        .round_key  (rk_next),
        .final_round(final_round),
        .next_state (round_out)
    );

    // idle_rdy_q is held low through reset so in_ready cannot show 1 while reset_n is low.
    assign bus.in_ready  = idle_rdy_q & ~clear;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= S_IDLE;
            state_q     <= '0;
            rk_q        <= '0;
            rcon_q      <= 8'h01;
            round_idx   <= '0;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            idle_rdy_q  <= 1'b0;
        end else if (clear) begin
            fsm_q       <= S_IDLE;
            state_q     <= '0;
            rk_q        <= '0;
            rcon_q      <= 8'h01;
            round_idx   <= '0;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            idle_rdy_q  <= 1'b1;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    idle_rdy_q <= 1'b1;
                    if (bus.in_valid && idle_rdy_q) begin
                        state_q    <= bus.in_data ^ bus.in_key;
                        rk_q       <= bus.in_key;
                        rcon_q     <= 8'h01;
                        round_idx  <= 4'd1;
                        busy       <= 1'b1;
                        idle_rdy_q <= 1'b0;
                        fsm_q      <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    state_q   <= round_out;
                    rk_q      <= rk_next;
                    rcon_q    <= xtime(rcon_q);
                    round_idx <= round_idx + 4'd1;
                    if (final_round) begin
                        out_valid_q <= 1'b1;
                        fsm_q       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy        <= 1'b0;
                        round_idx   <= '0;
                        idle_rdy_q  <= 1'b1;
                        fsm_q       <= S_IDLE;
                    end
                end
                default: begin
                    fsm_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: known vectors, handshake timing, abort/reset, and random blocks vs a reference AES.
module tb_aes_round_sequencer;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear   = 1'b0;
    logic       busy;
    logic [3:0] round_idx;
    int         cyc     = 0;
    int         total   = 0;
    int         bad     = 0;
    logic [7:0] sb [256];

    aes_round_sequencer_if bus();

    aes_round_sequencer #(.NR(10)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .bus      (bus),
        .busy     (busy),
        .round_idx(round_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    function automatic void build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] w [44][4];
        logic [7:0] tmp [4];
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] rc = 8'h01;
        logic [7:0] acc;
        logic [127:0] res = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = key[127-8*(4*i+j) -: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
            if (i % 4 == 0) begin
                for (int j = 0; j < 4; j++) tmp[j] = sb[w[i-1][(j+1)%4]];
                tmp[0] = tmp[0] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][r];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c+r)%4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rnd < 10) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++)
                            acc = acc ^ gmul(((k - r + 4) % 4 == 0) ? 8'h02 :
                                             ((k - r + 4) % 4 == 1) ? 8'h03 : 8'h01, t[k][c]);
                        s[r][c] = acc;
                    end else begin
                        s[r][c] = t[r][c];
                    end
                end
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ w[4*rnd+c][r];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = s[r][c];
        return res;
    endfunction

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic send_block(input logic [127:0] k, input logic [127:0] p,
                              output int acc_edge, output bit timed_out);
        int n = 0;
        bus.in_key   = k;
        bus.in_data  = p;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        timed_out = (n >= 64);
        acc_edge  = cyc + 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int out_edge, output bit timed_out);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        timed_out = (n >= 64);
        out_edge  = cyc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_data !== 128'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (round_idx !== 4'd0) begin bad++; $display("FAIL reset_round_idx: got %0d want 0", round_idx); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_vector1();
        int acc, e_out;
        bit to;
        send_block(K1, P1, acc, to);
        total++; if (to) begin bad++; $display("FAIL v1_accept: in_ready stayed %b want 1", bus.in_ready); end
        for (int i = 1; i <= 10; i++) begin
            total++;
            if (round_idx !== 4'(i) || busy !== 1'b1 || bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL v1_round: idx=%0d busy=%b out_valid=%b want idx=%0d busy=1 out_valid=0",
                         round_idx, busy, bus.out_valid, i);
            end
            @(negedge clk);
        end
        wait_out(e_out, to);
        total++; if (to || e_out - acc != 10) begin bad++; $display("FAIL v1_latency: got %0d want 10", e_out - acc); end
        total++; if (bus.out_data !== C1) begin bad++; $display("FAIL v1_data: got %h want %h", bus.out_data, C1); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== C1 || bus.in_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold: out_valid=%b data=%h in_ready=%b busy=%b want 1 %h 0 1",
                         bus.out_valid, bus.out_data, bus.in_ready, busy, C1);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1 || round_idx !== 4'd0) begin
            bad++;
            $display("FAIL bp_release: out_valid=%b busy=%b in_ready=%b idx=%0d want 0 0 1 0",
                     bus.out_valid, busy, bus.in_ready, round_idx);
        end
    endtask

    task automatic test_vector2();
        int acc, e_out;
        bit to;
        bus.out_ready = 1'b1;
        send_block(K2, P2, acc, to);
        wait_out(e_out, to);
        total++; if (to || e_out - acc != 10) begin bad++; $display("FAIL v2_latency: got %0d want 10", e_out - acc); end
        total++; if (bus.out_data !== C2) begin bad++; $display("FAIL v2_data: got %h want %h", bus.out_data, C2); end
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL v2_consume: out_valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        int accs[$];
        logic [127:0] outs[$];
        int n = 0;
        bus.out_ready = 1'b1;
        bus.in_key    = K1;
        bus.in_data   = P1;
        bus.in_valid  = 1'b1;
        while (outs.size() < 2 && n < 80) begin
            if (bus.out_valid === 1'b1) outs.push_back(bus.out_data);
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) accs.push_back(cyc + 1);
            @(negedge clk);
            n++;
            if (accs.size() == 1) begin
                bus.in_key  = K2;
                bus.in_data = P2;
            end
            if (accs.size() >= 2) bus.in_valid = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        total++;
        if (accs.size() != 2 || accs[1] - accs[0] != 12) begin
            bad++;
            $display("FAIL b2b_period: accepts=%0d spacing=%0d want 2 and 12",
                     accs.size(), (accs.size() == 2) ? accs[1] - accs[0] : -1);
        end
        total++;
        if (outs.size() != 2 || outs[0] !== C1 || outs[1] !== C2) begin
            bad++;
            $display("FAIL b2b_data: count=%0d first=%h second=%h want %h %h", outs.size(),
                     (outs.size() > 0) ? outs[0] : 128'h0, (outs.size() > 1) ? outs[1] : 128'h0, C1, C2);
        end
    endtask

    task automatic test_abort();
        int acc, e_out, n;
        bit to, seen;
        send_block(K1, P1, acc, to);
        n = 0;
        while (round_idx !== 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        clear = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0 || round_idx !== 4'd0 || bus.out_data !== 128'h0 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: busy=%b out_valid=%b idx=%0d data=%h in_ready=%b want all 0",
                     busy, bus.out_valid, round_idx, bus.out_data, bus.in_ready);
        end
        clear = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: in_ready=%b want 1", bus.in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL abort_no_output: out_valid rose got 1 want 0"); end
        send_block(K2, P2, acc, to);
        wait_out(e_out, to);
        total++; if (to || bus.out_data !== C2) begin bad++; $display("FAIL abort_v2: got %h want %h", bus.out_data, C2); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acc, e_out, n;
        bit to;
        send_block(K1, P1, acc, to);
        n = 0;
        while (round_idx !== 4'd3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, busy, round_idx, bus.in_ready, bus.out_data} !== '0) begin
            bad++;
            $display("FAIL rstmid_outputs: out_valid=%b busy=%b idx=%0d in_ready=%b data=%h want all 0",
                     bus.out_valid, busy, round_idx, bus.in_ready, bus.out_data);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_block(K1, P1, acc, to);
        wait_out(e_out, to);
        total++; if (to || e_out - acc != 10) begin bad++; $display("FAIL rstmid_latency: got %0d want 10", e_out - acc); end
        total++; if (bus.out_data !== C1) begin bad++; $display("FAIL rstmid_v1: got %h want %h", bus.out_data, C1); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        int acc, e_out, hold;
        bit to, stable;
        logic [127:0] k, p, exp;
        for (int it = 0; it < 12; it++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            exp = ref_encrypt(k, p);
            send_block(k, p, acc, to);
            wait_out(e_out, to);
            total++; if (to || e_out - acc != 10) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want 10", it, e_out - acc); end
            total++; if (bus.out_data !== exp) begin bad++; $display("FAIL rand_data[%0d]: got %h want %h", it, bus.out_data, exp); end
            hold = $urandom_range(0, 3);
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (bus.out_valid !== 1'b1 || bus.out_data !== exp) stable = 1'b0;
            end
            total++; if (!stable) begin bad++; $display("FAIL rand_hold[%0d]: output changed under backpressure want %h", it, exp); end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rand_consume[%0d]: out_valid=%b want 0", it, bus.out_valid); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;
        build_sbox();
        test_reset();
        test_vector1();
        test_backpressure();
        test_vector2();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL provide parameter NR, default 10, meaning the AES-128 round count; only 10 is supported.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port clear  input  1  synchronous abort; returns the block to IDLE.
REQ-005 SHALL provide port in_valid  input  1  requester presents a block.
REQ-006 SHALL provide port in_ready  output  1  sequencer can accept a block.
REQ-007 SHALL provide port in_data  input  128  plaintext, byte 0 in bits [127:120], column-major.
REQ-008 SHALL provide port in_key  input  128  cipher key, same byte order as in_data.
REQ-009 SHALL provide port out_valid  output  1  ciphertext available.
REQ-010 SHALL provide port out_ready  input  1  consumer takes the ciphertext.
REQ-011 SHALL provide port out_data  output  128  ciphertext, same byte order as in_data.
REQ-012 SHALL provide port busy  output  1  high in ROUND and DONE.
REQ-013 SHALL provide port round_idx  output  4  index of the round executed next (0 in IDLE).

Function
REQ-014 SHALL implement an FSM with states IDLE, ROUND and DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE with clear low; in_data and in_key are sampled only on the accept edge (in_valid & in_ready).
REQ-016 On the accept edge the block SHALL:
- load state = in_data ^ in_key, round key rk = in_key, rcon = 8'h01, round_idx = 1;
- go to ROUND.
REQ-017 Each ROUND edge SHALL:
- compute rk' = next key from rk and rcon (RotWord, SubWord, rcon XOR on word 0, chained XOR);
- apply one round to state with rk';
- store rk' and rcon = xtime(rcon) (0x80 -> 0x1b);
- increment round_idx.
REQ-018 A round SHALL be SubBytes, ShiftRows, MixColumns, AddRoundKey; when round_idx == NR, MixColumns SHALL be omitted.
REQ-019 The edge executing round NR SHALL move to DONE and set out_valid = 1, so out_valid rises exactly NR edges after the accept edge.
REQ-020 out_data SHALL equal the state register and SHALL be stable while out_valid = 1 and out_ready = 0, with no upper bound on the wait.
REQ-021 In DONE with out_ready = 1, the next edge SHALL clear out_valid and return to IDLE; in_ready is then high one cycle later, so back-to-back blocks have a period of NR + 2 cycles.
REQ-022 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-023 clear = 1 on any edge SHALL take priority over every other event:
- next state IDLE;
- out_valid = 0, round_idx = 0, state and rk zeroed;
- an accept coinciding with clear SHALL NOT occur, because in_ready is low while clear is high.
REQ-024 The sequencer SHALL hold exactly one block in flight; no output-to-input bypass.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, out_valid = 0, out_data = 0, busy = 0, round_idx = 0, rk = 0 and rcon = 8'h01; in_ready SHALL read 0 while reset_n is low.
REQ-026 Reset asserted mid-encryption SHALL discard the block; after release, the first accept SHALL behave as from power-up.

Structure
REQ-027 A shared package aes_pkg SHALL hold:
- the FSM state enum;
- the S-box table and sbox function;
- xtime, and the subword and rotword functions;
- the NR constant and the 128-bit block type.
REQ-028 One combinational sub-module, aes_round (inputs state, round key, final flag; output next state), SHALL hold the round datapath.
REQ-029 The key schedule SHALL be generated on the fly, one key per round, with no 1408-bit expanded-key storage.

Verification
REQ-030 Vector 1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 edges after accept.
REQ-031 Vector 2: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-032 Backpressure: out_ready held low 20 cycles after vector 1 -> out_valid and out_data stable throughout, in_ready 0; then out_ready 1 -> IDLE next edge.
REQ-033 Back-to-back: vectors 1 then 2 with in_valid held, out_ready = 1 -> both ciphertexts correct, accept edges 12 cycles apart.
REQ-034 Abort: clear pulsed at round_idx = 5 -> IDLE next edge, out_valid never rises; a following vector 2 gives the correct result.
REQ-035 Reset mid-op: reset_n low at round_idx = 3 -> all outputs 0 immediately; after release, vector 1 is correct.
